// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared definitions for the pipeline hazard controller.
//   - stall vector bit indices (pc, if, id, ex, mem, wb)
//   - canned stall vectors for each stall cause
//   - stall_cause encodings, doubling as the FSM state encoding
//   - RISC-V load opcode
//   - cause_sel(): priority pick of the active stall cause
package hazard_ctrl_pkg;

  // Per-stage hold bits of the stall vector.
  localparam int unsigned StallPc  = 0;
  localparam int unsigned StallIf  = 1;
  localparam int unsigned StallId  = 2;
  localparam int unsigned StallEx  = 3;
  localparam int unsigned StallMem = 4;
  localparam int unsigned StallWb  = 5;
  localparam int unsigned StallW   = 6;

  // Stall vectors per cause. The hazard vector holds pc/if/id only, so EX gets a bubble.
  localparam logic [StallW-1:0] StallVecNone = 6'b000000;
  localparam logic [StallW-1:0] StallVecIf   = 6'b000011;
  localparam logic [StallW-1:0] StallVecHaz  = 6'b000111;
  localparam logic [StallW-1:0] StallVecMem  = 6'b011111;

  // stall_cause encodings.
  localparam logic [1:0] CauseNone = 2'd0;
  localparam logic [1:0] CauseIf   = 2'd1;
  localparam logic [1:0] CauseHaz  = 2'd2;
  localparam logic [1:0] CauseMem  = 2'd3;

  localparam logic [6:0] OpcodeLoad = 7'b0000011;

  // FSM state is the stall cause itself, so the encodings match.
  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StIfw  = 2'd1,
    StHaz  = 2'd2,
    StMemw = 2'd3
  } state_e;

  // Highest-priority active cause: mem > load hazard > fetch.
  function automatic state_e cause_sel(input logic mem, input logic haz, input logic ifr);
    if (mem) begin
      return StMemw;
    end else if (haz) begin
      return StHaz;
    end else if (ifr) begin
      return StIfw;
    end
    return StRun;
  endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// load_scoreboard: one busy bit per architectural register, marking a load in flight.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   set_i, set_addr_i        mark set_addr_i busy (a load issued from ID)
//   clr_i, clr_addr_i        clear clr_addr_i (load result written back)
//   raddr1_i/2_i             lookup addresses
//   busy1_o/2_o              combinational busy flags for the lookups (x0 always 0)
module load_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned RegNum = 32,
  localparam int unsigned AddrW = $clog2(RegNum)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             set_i,
  input  logic [AddrW-1:0] set_addr_i,
  input  logic             clr_i,
  input  logic [AddrW-1:0] clr_addr_i,
  input  logic [AddrW-1:0] raddr1_i,
  input  logic [AddrW-1:0] raddr2_i,
  output logic             busy1_o,
  output logic             busy2_o
);

  // Bit 0 exists only to keep indexing simple; x0 is never marked.
  logic [RegNum-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_i && (clr_addr_i != '0)) begin
      busy_d[clr_addr_i] = 1'b0;
    end
    // Set is applied after clear so a same-cycle set on the same register wins.
    if (set_i && (set_addr_i != '0)) begin
      busy_d[set_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy1_o = (raddr1_i != '0) && busy_q[raddr1_i];
  assign busy2_o = (raddr2_i != '0) && busy_q[raddr2_i];

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use hazard detection, prioritised stall vector and branch flush control
// for the five-stage RISC-V pipeline.
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   id_valid_i                            ID holds a valid instruction
//   id_re1_i/id_re2_i, id_raddr1_i/2_i    ID source read enables and addresses
//   id_we_i, id_waddr_i, id_is_load_i     ID destination write and load flag
//   wb_load_done_i, wb_waddr_i            load result written to the regfile this cycle
//   stallreq_if_i, stallreq_mem_i         fetch / data memory not ready
//   ex_branch_taken_i                     EX resolved a taken branch or jump
//   stall_o[5:0]                          per-stage hold {wb,mem,ex,id,if,pc}
//   flush_if_id_o, flush_id_ex_o          bubble into if_id / id_ex
//   stall_cause_o                         registered cause: 0 none, 1 if, 2 hazard, 3 mem
//   haz_timeout_o                         sticky: hazard stall lasted HazTimeout cycles
//   stall_cycles_o                        saturating count of cycles with stall_o[0]
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned RegNum     = 32,
  parameter int unsigned HazTimeout = 64,
  localparam int unsigned AddrW     = $clog2(RegNum)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              id_valid_i,
  input  logic              id_re1_i,
  input  logic              id_re2_i,
  input  logic [AddrW-1:0]  id_raddr1_i,
  input  logic [AddrW-1:0]  id_raddr2_i,
  input  logic              id_we_i,
  input  logic [AddrW-1:0]  id_waddr_i,
  input  logic              id_is_load_i,
  input  logic              wb_load_done_i,
  input  logic [AddrW-1:0]  wb_waddr_i,
  input  logic              stallreq_if_i,
  input  logic              stallreq_mem_i,
  input  logic              ex_branch_taken_i,
  output logic [StallW-1:0] stall_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o,
  output logic [1:0]        stall_cause_o,
  output logic              haz_timeout_o,
  output logic [31:0]       stall_cycles_o
);

  localparam int unsigned WdogW = $clog2(HazTimeout + 1);
  localparam logic [WdogW-1:0] WdogMax = WdogW'(HazTimeout);

  state_e            state_q, state_d;
  logic [WdogW-1:0]  wdog_q, wdog_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       cycles_q, cycles_d;

  logic              src1_busy, src2_busy;
  logic              haz1, haz2, haz;
  logic [StallW-1:0] stall_raw;
  logic              flush_raw;
  logic              id_fire;

  // Hazard detection

  load_scoreboard #(
    .RegNum (RegNum)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .set_i      (id_fire),
    .set_addr_i (id_waddr_i),
    .clr_i      (wb_load_done_i),
    .clr_addr_i (wb_waddr_i),
    .raddr1_i   (id_raddr1_i),
    .raddr2_i   (id_raddr2_i),
    .busy1_o    (src1_busy),
    .busy2_o    (src2_busy)
  );

  // A load writing back this cycle is forwarded by the regfile, so it is not a hazard.
  assign haz1 = id_re1_i && src1_busy && !(wb_load_done_i && (wb_waddr_i == id_raddr1_i));
  assign haz2 = id_re2_i && src2_busy && !(wb_load_done_i && (wb_waddr_i == id_raddr2_i));
  assign haz  = id_valid_i && (haz1 || haz2);

  // Stall and flush

  always_comb begin
    stall_raw = StallVecNone;
    if (stallreq_mem_i) begin
      stall_raw = StallVecMem;
    end else if (haz) begin
      stall_raw = StallVecHaz;
    end else if (stallreq_if_i) begin
      stall_raw = StallVecIf;
    end
  end

  // Under a mem stall EX is held, so the taken branch is seen again once the stall lifts.
  assign flush_raw = ex_branch_taken_i && !stallreq_mem_i;

  // A flushed ID instruction never issues, so its load must not mark the scoreboard.
  assign id_fire = id_valid_i && !stall_raw[StallId] && id_we_i && id_is_load_i &&
                   (id_waddr_i != '0) && !flush_raw;

  // While reset is low the pipeline is released and both pipeline registers are bubbled.
  assign stall_o       = rst_ni ? stall_raw : StallVecNone;
  assign flush_if_id_o = !rst_ni || flush_raw;
  assign flush_id_ex_o = !rst_ni || flush_raw;

  // Cause FSM

  always_comb begin
    state_d = cause_sel(stallreq_mem_i, haz, stallreq_if_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  assign stall_cause_o = state_q;

  // Watchdog and stall counter

  always_comb begin
    wdog_d    = '0;
    timeout_d = timeout_q;
    cycles_d  = cycles_q;
    if (state_d == StHaz) begin
      // Saturate so a very long hazard cannot wrap back below the threshold.
      wdog_d = (wdog_q == WdogMax) ? wdog_q : wdog_q + 1'b1;
    end
    if (wdog_d == WdogMax) begin
      timeout_d = 1'b1;
    end
    if (stall_raw[StallPc] && (cycles_q != '1)) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
      cycles_q  <= '0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
      cycles_q  <= cycles_d;
    end
  end

  assign haz_timeout_o  = timeout_q;
  assign stall_cycles_o = cycles_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core. It keeps a load scoreboard over the integer register file and detects load-use hazards against ID's source operands. It also merges those hazards with IF and MEM busy requests into a single prioritised stall vector, and raises the branch flushes. It sits between the ID/regfile read path, the pipeline registers (if_id, id_ex, ex_mem, mem_wb) and the stage-stall inputs.

## Interface
- REG_NUM, 32, number of architectural registers; x0 is never tracked.
- HAZ_TIMEOUT, 64, consecutive hazard-stall cycles before `haz_timeout` sets.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- id_valid  in  1  ID holds a valid instruction.
- id_re1, id_re2  in  1 each  source-read enables.
- id_raddr1, id_raddr2  in  5 each  source register addresses.
- id_we  in  1  ID instruction writes rd.
- id_waddr  in  5  rd.
- id_is_load  in  1  ID instruction is a load (OpcodeLoad).
- wb_load_done  in  1  a load result is written to the regfile this cycle.
- wb_waddr  in  5  destination of that write.
- stallreq_if  in  1  instruction fetch is not ready.
- stallreq_mem  in  1  data memory access is not complete.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- stall  out  6  per-stage hold: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb.
- flush_if_id, flush_id_ex  out  1 each  insert a bubble into the pipeline register.
- stall_cause  out  2  registered cause: 0 none, 1 if, 2 load hazard, 3 mem.
- haz_timeout  out  1  sticky; cleared only by reset.
- stall_cycles  out  32  saturating count of cycles with `stall[0]`=1.

## Operation
- Scoreboard `busy[REG_NUM-1:1]`:
  - ID fire = `id_valid & ~stall[2] & id_we & id_is_load & id_waddr!=0`.
  - On ID fire, `busy[id_waddr]` sets.
  - On `wb_load_done & wb_waddr!=0`, `busy[wb_waddr]` clears.
  - Set and clear of the same register in one cycle: set wins.
- Load hazard `haz`:
  - Fires when `id_valid` and, for either source, re=1, raddr!=0, `busy[raddr]`=1, and not (`wb_load_done` & `wb_waddr`==raddr).
  - The same-cycle writeback case is excluded because the regfile forwards WB data.
- Stall priority, combinational: mem > haz > if.
  - `stallreq_mem`: stall=6'b011111.
  - else `haz`: stall=6'b000111 (bubble into EX).
  - else `stallreq_if`: stall=6'b000011.
  - else 6'b000000.
- Flush:
  - `ex_branch_taken & ~stallreq_mem` drives `flush_if_id`=`flush_id_ex`=1.
  - Under a mem stall the flush is suppressed. EX is held, so the branch re-asserts later.
  - A flush squashes the ID instruction. Its pending ID fire is also squashed, so the scoreboard does not set.
- FSM (state = stall cause): RUN, IFW, HAZ, MEMW.
  - Next state is the highest-priority active cause; RUN if none. Any state can move to any other.
  - `stall_cause` is the registered state.
- Watchdog:
  - A counter increments each cycle the next state is HAZ and resets to 0 otherwise.
  - When it reaches HAZ_TIMEOUT, `haz_timeout` sets and holds.
- `stall_cycles` increments when `stall[0]`=1 and saturates at 32'hFFFFFFFF.

## Timing
- Reset values: busy=0, state=RUN, stall_cause=0, haz_timeout=0, stall_cycles=0, watchdog=0.
- During reset, `stall` is forced to 0 and both flushes to 1.
- `stall` and the flushes are combinational from inputs and registered `busy`, with zero latency.
- Scoreboard, FSM and counters update one edge later.
- A load issued in cycle N is visible as busy to a dependent instruction in ID in cycle N+1.
- If reset asserts mid-stall, all state clears immediately. The first cycle after deassertion is RUN with an empty scoreboard.

## Structure
- Shared package/`defines.v`: stall bit indices, the `stall_cause` encodings, and `OpcodeLoad`.
- One sub-module, `load_scoreboard`: the busy bitmap with set/clear ports and two combinational lookup ports.

## Test plan
- Load x5 issued, then `add` reading x5 in ID the next cycle → stall=6'b000111 for each cycle until `wb_load_done` with waddr=5; on that cycle stall=0.
- Load into x0, then a reader of x0 → no stall; busy stays 0.
- `stallreq_mem`=1 together with a hazard and `ex_branch_taken` → stall=6'b011111, no flush, stall_cause=3 on the next cycle.
- `wb_load_done` for x7 in the same cycle a new load to x7 fires → busy[7]=1 afterwards.
- Hazard held for 64 consecutive cycles → `haz_timeout` rises and stays 1 after the hazard clears.
- Reset asserted while in MEMW with busy={x3,x9} → immediately stall=0, flushes=1; after release, `stall_cycles`=0 and a reader of x3 sees no stall.
